serial_addsub_ctrl: RTL
=======================

Name: serial_addsub_ctrl

Overview:
- Bit-serial arithmetic sequencer. It time-shares one 1-bit add/subtract cell across a WIDTH-bit operation, processing one bit per clock from LSB to MSB.
- Provides a start/ready/done handshake and registered Result, Cout and Ovf outputs.
- Sits between a requesting controller and the existing fulladder/fullsub cells. It trades latency for area in multi-bit ALU operations.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range: WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only while ready=1
- op  input  1  0 = add (A+B), 1 = subtract (A-B)
- A  input  WIDTH  operand A; captured when start is accepted
- B  input  WIDTH  operand B; captured when start is accepted
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN only
- done  output  1  single-cycle pulse; high in DONE only
- Result  output  WIDTH  final sum or difference; registered
- Cout  output  1  add: carry out of the MSB; sub: final borrow (1 when A < B unsigned)
- Ovf  output  1  two's-complement signed overflow

Behaviour:
- States: IDLE, RUN, DONE. ready, busy and done are decoded from the state.
- Reset: on any edge with rst=1:
  - state goes to IDLE; the bit counter, carry/borrow register and shift registers clear.
  - Result, Cout and Ovf clear to 0.
  - After reset: ready=1, busy=0, done=0.
  - rst has priority over every other event.
- IDLE:
  - A rising edge with start=1 latches A, B and op into internal registers.
  - It also clears the carry/borrow register to 0 and the bit counter to 0, and moves the state to RUN.
  - With start=0, the block stays in IDLE.
- RUN:
  - Each edge processes bit i = counter value:
    - add: sum = a_i ^ b_i ^ c; c_next = a_i&b_i | c&(a_i^b_i)
    - sub: diff = a_i ^ b_i ^ c; c_next = ~a_i&b_i | c&~(a_i^b_i)
  - The result bit shifts into the internal result shift register from the MSB side. The operand registers shift right by one. The counter increments.
  - On the edge where counter = WIDTH-1:
    - the state moves to DONE;
    - Result loads the complete shift-register value;
    - Cout loads c_next;
    - Ovf loads:
      - add: (a_msb == b_msb) & (r_msb != a_msb)
      - sub: (a_msb != b_msb) & (r_msb != a_msb)
- DONE:
  - done=1 for exactly one cycle, then the state returns to IDLE unconditionally.
- Latency: for a start sampled at edge 0, bits are processed at edges 1..WIDTH. done is high in the cycle after edge WIDTH. The earliest next start is sampled at edge WIDTH+2.
- start is ignored in RUN and DONE. It is never queued.
- If start is held high continuously, a new operation is accepted at the first edge in IDLE, using the operands present at that edge.
- Changes on A, B or op after acceptance have no effect on the operation in flight.
- Result, Cout and Ovf keep the previous operation's values throughout RUN. They change only on entry to DONE or on reset.
- Reset mid-RUN aborts the operation: no done pulse, and outputs clear to 0.
- Counter width is $clog2(WIDTH). The counter never wraps past WIDTH-1.

Decomposition:
- Shared package/header holds:
  - state encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - op encodings: OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module, serial_bit_cell:
  - instantiates the existing fulladder and fullsub cells;
  - selects their Sum/Diff and Carry/Borrow outputs with op;
  - inputs: a, b, cin, op; outputs: r, cout.
- The controller holds the FSM, counter, shift registers and output registers.

Test Plan (WIDTH=8):
1. add A=8'h3C, B=8'h25:
   - ready drops at edge 0 and busy is high for 8 cycles.
   - done pulses once after edge 8, with Result=8'h61, Cout=0, Ovf=0.
2. add boundary cases:
   - 8'hFF + 8'h01 -> Result=8'h00, Cout=1, Ovf=0.
   - 8'h7F + 8'h01 -> Result=8'h80, Cout=0, Ovf=1.
3. sub boundary cases:
   - 8'h05 - 8'h07 -> Result=8'hFE, Cout=1, Ovf=0.
   - 8'h80 - 8'h01 -> Result=8'h7F, Cout=0, Ovf=1.
   - 8'h10 - 8'h10 -> Result=8'h00, Cout=0, Ovf=0.
4. Input changes in flight:
   - Start add 8'h11 + 8'h22, then pulse start with A=8'hFF at RUN bit 3 and change B every cycle.
   - Required: Result=8'h33, exactly one done pulse, and the start pulse is discarded.
   - Result holds the prior value during RUN.
5. start held high with A/B stepping:
   - Required: back-to-back operations with exactly one IDLE cycle between each done and the next busy.
   - Each result matches the operands sampled in IDLE.
6. Reset during an operation:
   - Assert rst for one cycle at RUN bit 4 of 8'hAA + 8'h55.
   - Next cycle: state IDLE, ready=1, Result=0, Cout=0, Ovf=0, and no done pulse.
   - A following sub 8'h09 - 8'h03 yields Result=8'h06.

Source files
------------

// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared encodings and the signed-overflow rule for the bit-serial add/subtract sequencer.
package serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Overflow from the operand sign bits and the result sign bit.
    function automatic logic ovf_calc(input op_t op, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
        if (op == OP_ADD)
            return (a_msb == b_msb) && (r_msb != a_msb);
        else
            return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/fullsub.sv
// One-bit full subtractor cell (a - b - bin).
module fullsub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic borrow
);
    assign diff   = a ^ b ^ bin;
    assign borrow = (~a & b) | (bin & ~(a ^ b));
endmodule

// File: rtl/serial_bit_cell.sv
// Shared 1-bit arithmetic slice: adder and subtractor outputs muxed by op.
module serial_bit_cell
    import serial_addsub_ctrl_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic op,
    output logic r,
    output logic cout
);
    logic sum, carry, diff, borrow;

    fulladder u_add (.a(a), .b(b), .cin(cin), .sum(sum), .carry(carry));
    fullsub   u_sub (.a(a), .b(b), .bin(cin), .diff(diff), .borrow(borrow));

    assign r    = (op == OP_SUB) ? diff   : sum;
    assign cout = (op == OP_SUB) ? borrow : carry;
endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one bit per clock, LSB first, through a shared cell.
//   state   | meaning
//   IDLE    | ready for start; operands captured on accept
//   RUN     | one bit per edge, counter = bit index
//   DONE    | single-cycle done pulse, outputs valid
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, result_q, result_d;
    op_t              op_q, op_d;
    logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic             bit_r, bit_c;

    // Operands shift right, so the current bit is always at position 0.
    serial_bit_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .op   (op_q),
        .r    (bit_r),
        .cout (bit_c)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        c_d      = c_q;
        sr_d     = sr_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op_t'(op);
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                c_d  = bit_c;
                sr_d = {bit_r, sr_q[WIDTH-1:1]};
                a_d  = a_q >> 1;
                b_d  = b_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    result_d = {bit_r, sr_q[WIDTH-1:1]};
                    cout_d   = bit_c;
                    ovf_d    = ovf_calc(op_q, a_q[0], b_q[0], bit_r);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            c_q      <= 1'b0;
            sr_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            c_q      <= c_d;
            sr_q     <= sr_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;
    assign Cout   = cout_q;
    assign Ovf    = ovf_q;
endmodule
